// File: rtl/slice_ser_pkg.sv
// slice_ser_pkg: shared state encoding and lane-order helper for slice_serializer.
package slice_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Source lane for beat k: natural order, or pair-swapped (1,0,3,2,...).
  function automatic int lane_sel(input int k, input bit swap);
    return swap ? (k ^ 1) : k;
  endfunction

endpackage

// File: rtl/slice_ser_hold.sv
// slice_ser_hold: one-word holding register with a valid flag.
// Only instantiated when SLICE_SERIALIZER_SKID_EN is defined.
module slice_ser_hold #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A write wins over a read so that a same-cycle refill keeps the word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_en_i) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end else if (rd_en_i) begin
      full_d = 1'b0;
    end
  end

  // Holding register state, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/slice_serializer.sv
// slice_serializer: accepts a WIDTH-bit word and emits it as LANE-bit beats,
// in natural or pair-swapped lane order. All outputs come from registers.
// Optional macro SLICE_SERIALIZER_SKID_EN adds a one-word holding register
// so consecutive words stream with no idle cycle between them.
module slice_serializer #(
  parameter int WIDTH      = 16,
  parameter int LANE       = 4,
  parameter int SWAP_PAIRS = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LANE-1:0]       out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [((WIDTH/LANE) > 1 ? $clog2(WIDTH/LANE) : 1)-1:0] out_idx
);

  import slice_ser_pkg::*;

  localparam int NLANES = WIDTH / LANE;
  localparam int IDXW   = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam bit SWAP   = (SWAP_PAIRS != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic [LANE-1:0]  data_q, data_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  // Beat selection: which word and which beat number feed the output regs.
  logic [WIDTH-1:0] src_word;
  logic [IDXW-1:0]  src_k;
  logic             show;
  logic             in_accept;
  logic             done;
  logic             advance;
  int               src_lane;

  function automatic logic [LANE-1:0] lane_data(input logic [WIDTH-1:0] w, input int l);
    return w[l*LANE +: LANE];
  endfunction

`ifdef SLICE_SERIALIZER_SKID_EN
  logic             hold_wr;
  logic             hold_rd;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             active_free;

  slice_ser_hold #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (hold_wr),
    .wr_data_i (in_data),
    .rd_en_i   (hold_rd),
    .full_o    (hold_full),
    .data_o    (hold_data)
  );

  assign in_ready = !hold_full;
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign in_accept = in_valid && in_ready;
  assign done      = (state_q == SEND) && out_ready && last_q;
  assign advance   = (state_q == SEND) && out_ready && !last_q;

  // Next-state logic: load a new word, advance a beat, or return to IDLE.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    idx_d    = idx_q;
    last_d   = last_q;
    valid_d  = valid_q;
    src_word = word_q;
    src_k    = cnt_q;
    show     = 1'b0;
    src_lane = 0;
`ifdef SLICE_SERIALIZER_SKID_EN
    hold_wr     = 1'b0;
    hold_rd     = 1'b0;
    active_free = (state_q == IDLE) || done;
`endif

    if (advance) begin
      cnt_d = cnt_q + IDXW'(1);
      src_k = cnt_q + IDXW'(1);
      show  = 1'b1;
    end

`ifdef SLICE_SERIALIZER_SKID_EN
    if (active_free) begin
      if (hold_full) begin
        // Queued word goes out first; in_ready is low so no accept now.
        hold_rd  = 1'b1;
        word_d   = hold_data;
        src_word = hold_data;
        cnt_d    = '0;
        src_k    = '0;
        show     = 1'b1;
        state_d  = SEND;
      end else if (in_accept) begin
        word_d   = in_data;
        src_word = in_data;
        cnt_d    = '0;
        src_k    = '0;
        show     = 1'b1;
        state_d  = SEND;
      end else if (done) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    end else if (in_accept) begin
      hold_wr = 1'b1;
    end
`else
    if ((state_q == IDLE) && in_accept) begin
      word_d   = in_data;
      src_word = in_data;
      cnt_d    = '0;
      src_k    = '0;
      show     = 1'b1;
      state_d  = SEND;
    end else if (done) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
`endif

    if (show) begin
      src_lane = lane_sel(int'(src_k), SWAP);
      valid_d  = 1'b1;
      data_d   = lane_data(src_word, src_lane);
      idx_d    = IDXW'(src_lane);
      last_d   = (int'(src_k) == NLANES - 1);
    end
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_slice_serializer.sv
// tb_slice_serializer: scoreboard bench for slice_serializer, natural (dut0)
// and pair-swapped (dut1) instances. Expected beats are hand-written.
module tb_slice_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] in_data0, in_data1;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic [3:0]  out_data0, out_data1;
  logic        out_valid0, out_valid1;
  logic        out_ready0, out_ready1;
  logic        out_last0, out_last1;
  logic [1:0]  out_idx0, out_idx1;

  slice_serializer #(.WIDTH(16), .LANE(4), .SWAP_PAIRS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_last(out_last0), .out_idx(out_idx0));

  slice_serializer #(.WIDTH(16), .LANE(4), .SWAP_PAIRS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1), .out_idx(out_idx1));

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] i;
    logic       l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int total = 0;
  int bad = 0;

  logic win = 1'b0;
  int   wcyc = 0;
  int   wval = 0;
  int   seen_lo = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic exp0(input logic [3:0] d, input logic [1:0] i, input logic l);
    q0.push_back('{d: d, i: i, l: l});
  endtask

  task automatic exp1(input logic [3:0] d, input logic [1:0] i, input logic l);
    q1.push_back('{d: d, i: i, l: l});
  endtask

  task automatic wait_ready0();
    int n = 0;
    while (!in_ready0 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("in_ready0 timeout", 0, 1);
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("dut0 drain timeout", q0.size(), 0);
  endtask

  task automatic drain1();
    int n = 0;
    while (q1.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("dut1 drain timeout", q1.size(), 0);
  endtask

  // Monitor dut0: pop and compare on every output handshake.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected beat", int'(out_data0), -1);
      end else begin
        e = q0.pop_front();
        chk("dut0 data", int'(out_data0), int'(e.d));
        chk("dut0 idx", int'(out_idx0), int'(e.i));
        chk("dut0 last", int'(out_last0), int'(e.l));
      end
    end
  end

  // Monitor dut1.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected beat", int'(out_data1), -1);
      end else begin
        e = q1.pop_front();
        chk("dut1 data", int'(out_data1), int'(e.d));
        chk("dut1 idx", int'(out_idx1), int'(e.i));
        chk("dut1 last", int'(out_last1), int'(e.l));
      end
    end
  end

  // Window statistics for the back-to-back test.
  always @(negedge clk) begin
    if (win) begin
      wcyc++;
      if (out_valid0) wval++;
      if (!in_ready0) seen_lo = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_data0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b1;
    in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();

    chk("reset out_valid", int'(out_valid0), 0);
    chk("reset out_last", int'(out_last0), 0);
    chk("reset out_data", int'(out_data0), 0);
    chk("reset out_idx", int'(out_idx0), 0);
    chk("reset in_ready", int'(in_ready0), 1);
    chk("reset swap out_idx", int'(out_idx1), 0);
    rst_n = 1'b1;
    step();

    // Natural order, ABCD -> D,C,B,A.
    exp0(4'hD, 2'd0, 1'b0); exp0(4'hC, 2'd1, 1'b0);
    exp0(4'hB, 2'd2, 1'b0); exp0(4'hA, 2'd3, 1'b1);
    in_data0 = 16'hABCD; in_valid0 = 1'b1;
    wait_ready0();
    step();
    in_valid0 = 1'b0; in_data0 = 16'hFFFF;
    chk("t1 first beat valid", int'(out_valid0), 1);
    chk("t1 first beat data", int'(out_data0), 'hD);
    drain0();
    chk("t1 idle after word", int'(out_valid0), 0);

    // Pair swap, ABCD -> C,D,A,B.
    exp1(4'hC, 2'd1, 1'b0); exp1(4'hD, 2'd0, 1'b0);
    exp1(4'hA, 2'd3, 1'b0); exp1(4'hB, 2'd2, 1'b1);
    in_data1 = 16'hABCD; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0; in_data1 = 16'h0000;
    chk("t2 first beat valid", int'(out_valid1), 1);
    drain1();
    chk("t2 idle after word", int'(out_valid1), 0);

    // Backpressure: hold beat 1 of 1234 for three cycles.
    exp0(4'h4, 2'd0, 1'b0); exp0(4'h3, 2'd1, 1'b0);
    exp0(4'h2, 2'd2, 1'b0); exp0(4'h1, 2'd3, 1'b1);
    in_data0 = 16'h1234; in_valid0 = 1'b1;
    wait_ready0();
    step();
    in_valid0 = 1'b0;
    step();
    out_ready0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3 hold valid", int'(out_valid0), 1);
      chk("t3 hold data", int'(out_data0), 3);
      chk("t3 hold idx", int'(out_idx0), 1);
    end
    out_ready0 = 1'b1;
    drain0();

    // Back-to-back 1234 then 5678 with in_valid held.
    exp0(4'h4, 2'd0, 1'b0); exp0(4'h3, 2'd1, 1'b0);
    exp0(4'h2, 2'd2, 1'b0); exp0(4'h1, 2'd3, 1'b1);
    exp0(4'h8, 2'd0, 1'b0); exp0(4'h7, 2'd1, 1'b0);
    exp0(4'h6, 2'd2, 1'b0); exp0(4'h5, 2'd3, 1'b1);
    wcyc = 0; wval = 0; seen_lo = 0;
    in_data0 = 16'h1234; in_valid0 = 1'b1;
    wait_ready0();
    step();
    win = 1'b1;
    in_data0 = 16'h5678;
    wait_ready0();
    step();
    in_valid0 = 1'b0;
    drain0();
    win = 1'b0;
    chk("t4 valid beats", wval, 8);
`ifdef SLICE_SERIALIZER_SKID_EN
    chk("t4 window cycles", wcyc, 8);
    chk("t4 in_ready dropped", seen_lo, 1);
`else
    chk("t4 window cycles", wcyc, 9);
`endif
    step();

    // Reset mid-word: BEEF cut after beat 1, then 0F0F.
    exp0(4'hF, 2'd0, 1'b0); exp0(4'hE, 2'd1, 1'b0);
    exp0(4'hE, 2'd2, 1'b0); exp0(4'hB, 2'd3, 1'b1);
    in_data0 = 16'hBEEF; in_valid0 = 1'b1;
    wait_ready0();
    step();
    in_valid0 = 1'b0;
    step();
    chk("t5 beat1 shown", int'(out_data0), 'hE);
    rst_n = 1'b0;
    q0.delete();
    step();
    rst_n = 1'b1;
    chk("t5 reset out_valid", int'(out_valid0), 0);
    chk("t5 reset out_data", int'(out_data0), 0);
    chk("t5 reset out_idx", int'(out_idx0), 0);
    chk("t5 reset out_last", int'(out_last0), 0);
    chk("t5 reset in_ready", int'(in_ready0), 1);
    step();
    chk("t5 still idle", int'(out_valid0), 0);
    exp0(4'hF, 2'd0, 1'b0); exp0(4'h0, 2'd1, 1'b0);
    exp0(4'hF, 2'd2, 1'b0); exp0(4'h0, 2'd3, 1'b1);
    in_data0 = 16'h0F0F; in_valid0 = 1'b1;
    wait_ready0();
    step();
    in_valid0 = 1'b0;
    drain0();
    step();
    chk("t5 idle after word", int'(out_valid0), 0);

    chk("q0 empty", q0.size(), 0);
    chk("q1 empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
